// File: rtl/gray_counter.sv
// Up/down Gray-code counter with synchronous load and terminal-count flag.
// The count lives only in a Gray-coded register. Each step decodes it to
// binary, adds or subtracts one, and re-encodes, so g changes one bit per step.
// Optional build macro GRAY_COUNTER_SATURATE_EN: when defined, the counter
// holds at its terminal value instead of wrapping, and wrap is never asserted.
module gray_counter #(
   parameter int unsigned WIDTH = 4
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             en,
   input  logic             up,
   input  logic             ld,
   input  logic [WIDTH-1:0] d,
   output logic [WIDTH-1:0] g,
   output logic [WIDTH-1:0] b,
   output logic             tc,
   output logic             wrap
);

   logic [WIDTH-1:0] g_q;
   logic             wrap_q;
   logic [WIDTH-1:0] bin;
   logic [WIDTH-1:0] bin_step;
   logic [WIDTH-1:0] g_step;
   logic [WIDTH-1:0] g_load;
   logic             tc_int;

   // Gray-to-binary decode: each binary bit is the XOR of all Gray bits at or above it
   always_comb begin
      bin = '0;
      for (int i = 0; i < int'(WIDTH); i++) begin
         bin[i] = ^(g_q >> i);
      end
   end

   // Next-step value in binary and Gray, terminal-count flag, and load encoding
   always_comb begin
      bin_step = up ? (bin + WIDTH'(1)) : (bin - WIDTH'(1));
      g_step   = bin_step ^ (bin_step >> 1);
      g_load   = d ^ (d >> 1);
      tc_int   = up ? (bin == {WIDTH{1'b1}}) : (bin == '0);
   end

   // State update with priority rst > ld > en > hold
   always_ff @(posedge clk) begin
      if (rst) begin
         g_q    <= '0;
         wrap_q <= 1'b0;
      end else if (ld) begin
         g_q    <= g_load;
         wrap_q <= 1'b0;
      end else if (en) begin
`ifdef GRAY_COUNTER_SATURATE_EN
         // Stick at the terminal value in the current direction
         if (!tc_int) begin
            g_q <= g_step;
         end
         wrap_q <= 1'b0;
`else
         g_q    <= g_step;
         wrap_q <= tc_int;
`endif
      end else begin
         wrap_q <= 1'b0;
      end
   end

   assign g    = g_q;
   assign b    = bin;
   assign tc   = tc_int;
   assign wrap = wrap_q;

endmodule
